// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation codes, FSM state encoding and iteration-counter sizing.
package muldiv_pkg;

    localparam logic [1:0] MDOP_MULU = 2'b00;
    localparam logic [1:0] MDOP_MULS = 2'b01;
    localparam logic [1:0] MDOP_DIVU = 2'b10;
    localparam logic [1:0] MDOP_DIVS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Bits needed to count WIDTH iterations (0 .. WIDTH-1), never less than one
    function automatic int cnt_width(input int w);
        if (w <= 2) begin
            return 1;
        end
        return $clog2(w);
    endfunction

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate: used both to take operand
// magnitudes and to restore the sign of the final result.
module twos_negate #(
    parameter int WIDTH = 16
) (
    input  logic             neg_i,
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle multiply/divide unit. Operands are reduced to magnitudes at
// start, WIDTH shift-add (MUL) or restoring shift-subtract (DIV) iterations
// run on a 2*WIDTH accumulator, and signs are re-applied in the FIX cycle.
module alu_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 is_div_q;
    logic                 neg_a_q;
    logic                 neg_b_q;
    logic                 bzero_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic [2*WIDTH-1:0]   acc_q;

    logic                 start_ok;
    logic                 in_signed;
    logic                 in_div;
    logic                 neg_a_in;
    logic                 neg_b_in;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_step;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // A flush in the same cycle as start squashes the request
    assign start_ok  = (state_q == S_IDLE) && start && !flush;
    assign in_signed = (mdop == MDOP_MULS) || (mdop == MDOP_DIVS);
    assign in_div    = (mdop == MDOP_DIVU) || (mdop == MDOP_DIVS);
    assign neg_a_in  = in_signed && operand_a[WIDTH-1];
    assign neg_b_in  = in_signed && operand_b[WIDTH-1];

    twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .neg_i (neg_a_in),
        .val_i (operand_a),
        .val_o (abs_a)
    );

    twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .neg_i (neg_b_in),
        .val_i (operand_b),
        .val_o (abs_b)
    );

    // Product sign is the XOR of the operand signs
    twos_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg_i (neg_a_q ^ neg_b_q),
        .val_i (acc_q),
        .val_o (prod_fix)
    );

    // Quotient truncates toward zero: negate when operand signs differ
    twos_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .neg_i (neg_a_q ^ neg_b_q),
        .val_i (acc_q[WIDTH-1:0]),
        .val_o (quo_fix)
    );

    // Remainder follows the dividend's sign
    twos_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .neg_i (neg_a_q),
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .val_o (rem_fix)
    );

    // One iteration of shift-add multiply or restoring divide on the accumulator
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // When div_ge holds the true difference is below the divisor, so W bits suffice
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: flush returns to IDLE from any busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: busy covers RUN and FIX, dropping in the done cycle
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Iteration counter, done pulse and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                cnt_q <= '0;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state_q == S_FIX) && !flush) begin
                done <= 1'b1;
                if (!is_div_q) begin
                    result_hi <= prod_fix[2*WIDTH-1:WIDTH];
                    result_lo <= prod_fix[WIDTH-1:0];
                    div_zero  <= 1'b0;
                end else if (bzero_q) begin
                    result_hi <= a_raw_q;
                    result_lo <= '1;
                    div_zero  <= 1'b1;
                end else begin
                    result_hi <= rem_fix;
                    result_lo <= quo_fix;
                    div_zero  <= 1'b0;
                end
            end
        end
    end

    // Operand capture at start, then one accumulator iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (start_ok) begin
            is_div_q <= in_div;
            neg_a_q  <= neg_a_in;
            neg_b_q  <= neg_b_in;
            bzero_q  <= (operand_b == '0);
            a_raw_q  <= operand_a;
            if (in_div) begin
                opnd_q <= abs_b;
                acc_q  <= {{WIDTH{1'b0}}, abs_a};
            end else begin
                opnd_q <= abs_a;
                acc_q  <= {{WIDTH{1'b0}}, abs_b};
            end
        end else if (state_q == S_RUN) begin
            acc_q <= acc_step;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit (WIDTH=16) with hand-computed results.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  mdop = 2'b00;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result_hi;
    logic [15:0] result_lo;
    logic        div_zero;

    int n_cmp = 0;
    int n_mis = 0;

    alu_muldiv_unit #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .mdop      (mdop),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs
    task automatic launch(input string tag, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b);
        mdop = op;
        operand_a = a;
        operand_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdop = ~op;
        operand_a = 16'hDEAD;
        operand_b = 16'h0000;
        chk({tag, " accept busy/done"}, {30'd0, busy, done}, 32'h2);
    endtask

    // n_busy edges with busy=1/done=0, then the done cycle with results
    task automatic expect_done(input string tag, input int n_busy,
                               input logic [15:0] hi, input logic [15:0] lo, input logic dz);
        int bad = 0;
        for (int k = 0; k < n_busy; k++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        chk({tag, " busy window"}, bad, 0);
        @(posedge clk);
        #1;
        chk({tag, " busy/done"}, {30'd0, busy, done}, 32'h1);
        chk({tag, " hi"}, {16'd0, result_hi}, {16'd0, hi});
        chk({tag, " lo"}, {16'd0, result_lo}, {16'd0, lo});
        chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, dz});
    endtask

    initial begin
        int pulses;

        #2;
        chk("reset ctl", {29'd0, busy, done, div_zero}, 32'h0);
        chk("reset res", {result_hi, result_lo}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch("mulu ffff*ffff", 2'b00, 16'hFFFF, 16'hFFFF);
        expect_done("mulu ffff*ffff", 16, 16'hFFFE, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        chk("done single pulse", {31'd0, done}, 32'h0);

        launch("muls -3*5", 2'b01, 16'hFFFD, 16'h0005);
        expect_done("muls -3*5", 16, 16'hFFFF, 16'hFFF1, 1'b0);
        launch("muls 8000*8000", 2'b01, 16'h8000, 16'h8000);
        expect_done("muls 8000*8000", 16, 16'h4000, 16'h0000, 1'b0);

        launch("divu 100/7", 2'b10, 16'd100, 16'd7);
        expect_done("divu 100/7", 16, 16'h0002, 16'h000E, 1'b0);
        launch("divs -7/2", 2'b11, 16'hFFF9, 16'h0002);
        expect_done("divs -7/2", 16, 16'hFFFF, 16'hFFFD, 1'b0);

        launch("divu 1234/0", 2'b10, 16'h1234, 16'h0000);
        expect_done("divu 1234/0", 16, 16'h1234, 16'hFFFF, 1'b1);
        launch("divs 8000/-1", 2'b11, 16'h8000, 16'hFFFF);
        expect_done("divs 8000/-1", 16, 16'h0000, 16'h8000, 1'b0);

        // A start arriving while busy must not disturb the operation in flight
        launch("mulu 3*4", 2'b00, 16'd3, 16'd4);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        mdop = 2'b10;
        operand_a = 16'd9;
        operand_b = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_done("mulu 3*4 ign start", 11, 16'h0000, 16'h000C, 1'b0);

        // Back-to-back: request accepted in the done cycle
        launch("b2b mulu 5*6", 2'b00, 16'd5, 16'd6);
        expect_done("b2b mulu 5*6", 16, 16'h0000, 16'h001E, 1'b0);

        // flush and start together in IDLE: start dropped
        mdop = 2'b00;
        operand_a = 16'd2;
        operand_b = 16'd2;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        chk("flush+start idle", {30'd0, busy, done}, 32'h0);

        // flush at edge 8: no done, earlier results kept
        launch("flush mulu 7*7", 2'b00, 16'd7, 16'd7);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy/done", {30'd0, busy, done}, 32'h0);
        chk("flush kept res", {result_hi, result_lo}, 32'h0000_001E);
        chk("flush kept dz", {31'd0, div_zero}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("flush no done", pulses, 0);

        // Asynchronous reset in the middle of an operation
        launch("rst divu 1234/0", 2'b10, 16'h1234, 16'h0000);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst ctl", {29'd0, busy, done, div_zero}, 32'h0);
        chk("async rst res", {result_hi, result_lo}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        launch("divs 7/-2", 2'b11, 16'h0007, 16'hFFFE);
        expect_done("divs 7/-2", 16, 16'h0001, 16'hFFFD, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
